obstacle_renderer: RTL and testbench



---
 rtl/obstacle_renderer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_obstacle_renderer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_renderer.sv
// ---------------------------------------------------------------------------
// obstacle_renderer
//
// Purpose:
//   Turns the positions of N_OBS obstacles into a serial stream of pixel
//   writes for the VGA adapter. On every accepted frame tick the renderer
//   erases each obstacle at the position it last drew it (if any), snapshots
//   the current positions, then draws every obstacle as a BLK_W x BLK_H block.
//
// Optional feature (macro OBS_HIT_EN):
//   When defined, adds player_x / player_y inputs and a sticky hit output that
//   rises when a drawn (non-clipped) obstacle pixel lands inside the 4x4
//   player box. hit clears on reset and on the next accepted frame tick.
//   When undefined, those ports and the logic behind them do not exist.
//
// Ports:
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   frame_tick  in   start-of-frame request, only looked at while idle
//   obs_x       in   packed X positions, obstacle i at [8i+7:8i]
//   obs_y       in   packed Y positions, obstacle i at [7i+6:7i]
//   pix_ready   in   write port accepts the presented pixel this cycle
//   player_x    in   (OBS_HIT_EN) player box X origin
//   player_y    in   (OBS_HIT_EN) player box Y origin
//   hit         out  (OBS_HIT_EN) sticky obstacle/player overlap flag
//   x, y        out  pixel coordinates
//   colour      out  pixel colour
//   plot        out  pixel valid
//   busy        out  high from the cycle after an accepted tick through DONE
//   frame_done  out  one-cycle pulse in the DONE state
//   state_dbg   out  current FSM state, for observation only
//
// Handshake (plot / pix_ready):
//   A pixel transfers on a rising clock edge where plot=1 and pix_ready=1.
//   While plot=1 and pix_ready=0, x/y/colour/plot stay unchanged. plot never
//   depends combinationally on pix_ready. A pixel that falls outside the
//   160x120 playfield is skipped: it occupies one cycle with plot=0 and the
//   walk advances without waiting for pix_ready.
// ---------------------------------------------------------------------------
module obstacle_renderer #(
    parameter int         N_OBS      = 10,
    parameter int         BLK_W      = 4,
    parameter int         BLK_H      = 4,
    parameter logic [2:0] OBS_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 frame_tick,
    input  logic [8*N_OBS-1:0]   obs_x,
    input  logic [7*N_OBS-1:0]   obs_y,
    input  logic                 pix_ready,
`ifdef OBS_HIT_EN
    input  logic [7:0]           player_x,
    input  logic [6:0]           player_y,
    output logic                 hit,
`endif
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 frame_done,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ERASE = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] DRAW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Counter widths; a 1-pixel dimension still gets a 1-bit counter.
    localparam int IW  = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int DXW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int DYW = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    localparam logic [IW-1:0]  LAST_OBS = IW'(N_OBS - 1);
    localparam logic [DXW-1:0] LAST_DX  = DXW'(BLK_W - 1);
    localparam logic [DYW-1:0] LAST_DY  = DYW'(BLK_H - 1);

    // -----------------------------------------------------------------------
    // State and walk counters
    // -----------------------------------------------------------------------
    logic [2:0]         state_q, state_d;
    logic [IW-1:0]      obs_idx_q, obs_idx_d;
    logic [DXW-1:0]     dx_q, dx_d;
    logic [DYW-1:0]     dy_q, dy_d;

    // Snapshot of the positions that were (or are being) drawn this frame;
    // the erase pass of the next frame walks these same positions.
    logic [8*N_OBS-1:0] shadow_x_q;
    logic [7*N_OBS-1:0] shadow_y_q;
    logic               shadow_valid_q, shadow_valid_d;
    logic               latch_en;

    // -----------------------------------------------------------------------
    // Current pixel
    // -----------------------------------------------------------------------
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic       clip;
    logic       in_walk;
    logic       advance;
    logic       last_pixel;
    logic       tick_accept;

    always_comb begin
        base_x = 8'd0;
        base_y = 7'd0;
        for (int i = 0; i < N_OBS; i++) begin
            if (obs_idx_q == IW'(i)) begin
                base_x = shadow_x_q[8*i +: 8];
                base_y = shadow_y_q[7*i +: 7];
            end
        end
    end

    // Widened sums so blocks hanging off the right/bottom edge are detected
    // instead of wrapping back onto the playfield.
    assign pix_x = 9'(base_x) + 9'(dx_q);
    assign pix_y = 8'(base_y) + 8'(dy_q);
    assign clip  = (pix_x > 9'd159) || (pix_y > 8'd119);

    assign in_walk     = (state_q == ERASE) || (state_q == DRAW);
    assign advance     = in_walk && (clip || pix_ready);
    assign last_pixel  = (obs_idx_q == LAST_OBS) && (dx_q == LAST_DX) &&
                         (dy_q == LAST_DY);
    assign tick_accept = (state_q == IDLE) && frame_tick;

    // Outputs are decoded straight from registered state, so an asynchronous
    // reset drops plot at once and held pixels stay stable while stalled.
    assign plot       = in_walk && !clip;
    assign x          = plot ? pix_x[7:0] : 8'd0;
    assign y          = plot ? pix_y[6:0] : 7'd0;
    assign colour     = plot ? ((state_q == DRAW) ? OBS_COLOUR : BG_COLOUR)
                             : 3'd0;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign state_dbg  = state_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        obs_idx_d      = obs_idx_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        shadow_valid_d = shadow_valid_q;
        latch_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d   = shadow_valid_q ? ERASE : LATCH;
                    obs_idx_d = '0;
                    dx_d      = '0;
                    dy_d      = '0;
                end
            end

            ERASE, DRAW: begin
                if (advance) begin
                    if (last_pixel) begin
                        obs_idx_d = '0;
                        dx_d      = '0;
                        dy_d      = '0;
                        state_d   = (state_q == ERASE) ? LATCH : DONE;
                    end else if (dx_q != LAST_DX) begin
                        dx_d = dx_q + DXW'(1);
                    end else if (dy_q != LAST_DY) begin
                        dx_d = '0;
                        dy_d = dy_q + DYW'(1);
                    end else begin
                        dx_d      = '0;
                        dy_d      = '0;
                        obs_idx_d = obs_idx_q + IW'(1);
                    end
                end
            end

            LATCH: begin
                latch_en       = 1'b1;
                shadow_valid_d = 1'b1;
                state_d        = DRAW;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            obs_idx_q      <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            obs_idx_q      <= obs_idx_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow_x_q <= '0;
            shadow_y_q <= '0;
        end else if (latch_en) begin
            shadow_x_q <= obs_x;
            shadow_y_q <= obs_y;
        end
    end

`ifdef OBS_HIT_EN
    // -----------------------------------------------------------------------
    // Player collision flag
    // -----------------------------------------------------------------------
    logic hit_q, hit_d;
    logic in_box;

    // Player box is fixed at 4x4 regardless of the obstacle block size.
    assign in_box = (pix_x >= 9'(player_x)) && (pix_x <= 9'(player_x) + 9'd3) &&
                    (pix_y >= 8'(player_y)) && (pix_y <= 8'(player_y) + 8'd3);

    always_comb begin
        hit_d = hit_q;
        if (tick_accept) begin
            hit_d = 1'b0;
        end else if ((state_q == DRAW) && plot && pix_ready && in_box) begin
            hit_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit = hit_q;
`else
    // tick_accept only feeds the collision flag.
    logic unused_tick_accept;
    assign unused_tick_accept = tick_accept;
`endif

endmodule

// File: tb/tb_obstacle_renderer.sv
// ---------------------------------------------------------------------------
// tb_obstacle_renderer
//
// Bench for obstacle_renderer. Each accepted frame tick pushes the full
// expected pixel stream (erase of the previous snapshot, then draw of the new
// one) into exp_q, computed from block geometry with plain loops. A monitor
// pops and compares one entry per transferred pixel, checks that stalled
// outputs hold, and checks frame_done bookkeeping. Build with +define+OBS_HIT_EN
// to exercise the collision flag.
// ---------------------------------------------------------------------------
module tb_obstacle_renderer;

    localparam int         N     = 10;
    localparam int         BW    = 4;
    localparam int         BH    = 4;
    localparam logic [2:0] OBS_C = 3'b100;
    localparam logic [2:0] BG_C  = 3'b000;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic           clock = 1'b0;
    logic           resetn;
    logic           frame_tick;
    logic [8*N-1:0] obs_x;
    logic [7*N-1:0] obs_y;
    logic           pix_ready;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot;
    logic           busy;
    logic           frame_done;
    logic [2:0]     state_dbg;
`ifdef OBS_HIT_EN
    logic [7:0]     player_x;
    logic [6:0]     player_y;
    logic           hit;
`endif

    always #5 clock = ~clock;

    obstacle_renderer #(
        .N_OBS(N), .BLK_W(BW), .BLK_H(BH), .OBS_COLOUR(OBS_C), .BG_COLOUR(BG_C)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .obs_x      (obs_x),
        .obs_y      (obs_y),
        .pix_ready  (pix_ready),
`ifdef OBS_HIT_EN
        .player_x   (player_x),
        .player_y   (player_y),
        .hit        (hit),
`endif
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          tick_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          exp_dones = 0;
    int          ready_mode = 0;     // 0: ready high (with optional stall window), 1: random
    bit          stall_en = 1'b0;
    logic [17:0] exp_q[$];

    // Reference snapshot of what the renderer should have drawn last.
    int          m_x[N];
    int          m_y[N];
    bit          m_valid = 1'b0;
    logic        exp_hit = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // pix_ready changes shortly after each rising edge.
    initial forever begin
        @(posedge clock);
        #2;
        if (ready_mode == 1)
            pix_ready = ($urandom_range(0, 3) != 0);
        else if (stall_en && (cyc - tick_cyc) >= 200 && (cyc - tick_cyc) <= 202)
            pix_ready = 1'b0;
        else
            pix_ready = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    function automatic logic [17:0] pix_word(input int px, input int py, input logic [2:0] c);
        logic [7:0] xx;
        logic [6:0] yy;
        xx = px[7:0];
        yy = py[6:0];
        return {xx, yy, c};
    endfunction

    task automatic push_blocks(input logic [2:0] col, input bit is_draw);
        for (int i = 0; i < N; i++)
            for (int dy = 0; dy < BH; dy++)
                for (int dx = 0; dx < BW; dx++) begin
                    int px;
                    int py;
                    px = m_x[i] + dx;
                    py = m_y[i] + dy;
                    if (px < 160 && py < 120) begin
                        exp_q.push_back(pix_word(px, py, col));
`ifdef OBS_HIT_EN
                        if (is_draw && px >= int'(player_x) && px <= int'(player_x) + 3 &&
                            py >= int'(player_y) && py <= int'(player_y) + 3)
                            exp_hit = 1'b1;
`endif
                    end
                end
        if (!is_draw) exp_hit = exp_hit;
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic set_obs(input int i, input int xv, input int yv);
        obs_x[8*i +: 8] = xv[7:0];
        obs_y[7*i +: 7] = yv[6:0];
    endtask

    task automatic start_frame();
        if (m_valid) push_blocks(BG_C, 1'b0);
        for (int i = 0; i < N; i++) begin
            m_x[i] = int'(obs_x[8*i +: 8]);
            m_y[i] = int'(obs_y[7*i +: 7]);
        end
        m_valid = 1'b1;
        exp_hit = 1'b0;
        push_blocks(OBS_C, 1'b1);
        @(posedge clock);
        #1;
        frame_tick = 1'b1;
        tick_cyc   = cyc;
        exp_dones++;
        @(posedge clock);
        #1;
        frame_tick = 1'b0;
        check("busy_after_tick", busy, 1);
`ifdef OBS_HIT_EN
        check("hit_cleared_by_tick", hit, 0);
`endif
    endtask

    task automatic wait_done(input int exp_len);
        for (int n = 0; n < 4000 && done_cnt < exp_dones; n++) @(posedge clock);
        #1;
        if (done_cnt < exp_dones) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got %0d frame_done pulses expected %0d", done_cnt, exp_dones);
            exp_q.delete();
            done_cnt = exp_dones;
        end else begin
            if (exp_len >= 0) check("frame_len", done_cyc - tick_cyc, exp_len);
            check("busy_idle_after_done", busy, 0);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial begin
        logic        prev_stall;
        logic [18:0] prev_out;
        logic [17:0] e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clock);
            if (resetn !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold_while_stalled", {x, y, colour, plot}, prev_out);
                if (plot && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_pixel: got %0h expected none", {x, y, colour});
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {x, y, colour}, e);
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("pixels_left_at_done", exp_q.size(), 0);
                    check("busy_at_done", busy, 1);
`ifdef OBS_HIT_EN
                    check("hit_at_done", hit, exp_hit);
`endif
                end
                prev_stall = plot && !pix_ready;
                prev_out   = {x, y, colour, plot};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        frame_tick = 1'b0;
        pix_ready  = 1'b1;
        obs_x      = '0;
        obs_y      = '0;
`ifdef OBS_HIT_EN
        player_x   = 8'd0;
        player_y   = 7'd0;
`endif
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("reset_x", x, 0);
        check("reset_y", y, 0);
        check("reset_colour", colour, 0);
        check("reset_plot", plot, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;

        // First frame: no erase; inputs scrambled after LATCH must not matter.
        for (int i = 0; i < N; i++) set_obs(i, 2, 0);
        start_frame();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) set_obs(i, $urandom_range(0, 255), $urandom_range(0, 127));
        wait_done(162);

        // Second frame: erase old snapshot, obstacle 0 partly off the bottom.
        for (int i = 0; i < N; i++) set_obs(i, 2, 0);
        set_obs(0, 2, 119);
        start_frame();
        wait_done(322);

        // Three-cycle stall inside the draw pass.
        for (int i = 0; i < N; i++) set_obs(i, i * 15, 20);
        stall_en = 1'b1;
        start_frame();
        wait_done(325);
        stall_en = 1'b0;

        // Ticks while busy are ignored.
        for (int i = 0; i < N; i++) set_obs(i, i * 12 + 3, 60 + i);
        start_frame();
        repeat (49) @(posedge clock);
        #1 frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        repeat (149) @(posedge clock);
        #1 frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        wait_done(322);
        repeat (20) @(posedge clock);
        check("one_done_per_tick", done_cnt, exp_dones);

`ifdef OBS_HIT_EN
        for (int i = 0; i < N; i++) set_obs(i, 140, 5);
        set_obs(3, 32, 42);
        player_x = 8'd30;
        player_y = 7'd40;
        start_frame();
        wait_done(322);
        check("hit_set", hit, 1);
        player_x = 8'd100;
        player_y = 7'd100;
        start_frame();
        wait_done(322);
        check("hit_stays_clear", hit, 0);
`endif

        // Random positions (including clipped ones) with random back-pressure.
        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) set_obs(i, $urandom_range(0, 170), $urandom_range(0, 127));
`ifdef OBS_HIT_EN
            player_x = 8'($urandom_range(0, 160));
            player_y = 7'($urandom_range(0, 120));
`endif
            start_frame();
            wait_done(-1);
        end
        ready_mode = 0;

        // Reset in the middle of the draw pass.
        for (int i = 0; i < N; i++) set_obs(i, i * 10 + 1, 30);
        start_frame();
        while ((cyc - tick_cyc) < 170) @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("midreset_plot", plot, 0);
        check("midreset_busy", busy, 0);
        check("midreset_x", x, 0);
        check("midreset_colour", colour, 0);
        exp_q.delete();
        m_valid = 1'b0;
        exp_hit = 1'b0;
        exp_dones--;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < N; i++) set_obs(i, 150 - i * 9, 100 + i);
        start_frame();
        wait_done(162);

        repeat (5) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
